prf_free_list: RTL and testbench
================================

// Module: prf_free_list
// PURPOSE
//  Circular FIFO of free physical register (PRF) tags, sitting between dispatch/rename and the ROB.
//  - Dispatch pops one tag per cycle for a destination-writing instruction.
//  - ROB commit pushes back the stale PRF tag of the committing instruction.
//  - A retirement head pointer gives single-cycle recovery when a mispredicted branch commits.
// PARAMETERS
//  PRF_width  6   bits of a PRF tag (PRF_NUM = 64)
//  ARF_width  5   bits of an ARF index (ARF_NUM = 32)
//  FL_SIZE    32  entries = PRF_NUM - ARF_NUM; must be a power of two
// PORTS
//  clock                     in   1          single clock; all state updates on posedge
//  reset                     in   1          asynchronous, active-low; asserted (0) clears all state immediately
//  id_dispatch_req_in        in   1          dispatching a valid instruction that needs a new dest PRF
//  fl_PRF_num_out            out  PRF_width  tag at speculative head; valid when fl_grant_out=1
//  fl_grant_out              out  1          pop accepted this cycle (combinational)
//  fl_empty_out              out  1          no free tag; dispatch must stall
//  fl_free_count_out         out  6          free tags, 0..FL_SIZE (registered pointers)
//  ROB_commit_in             in   1          ROB head retires this cycle
//  ROB_has_dest_in           in   1          retiring instruction was allocated a PRF at dispatch
//  ROB_old_PRF_num_in        in   PRF_width  stale PRF tag released by the retiring instruction
//  ROB_branch_mispredict_in  in   1          retiring instruction is a mispredicted branch; squash
// BEHAVIOUR
//  - State: entry[FL_SIZE]; spec_head, retire_head and tail are each 6 bits (5-bit index plus wrap bit).
//  - Reset (reset=0): entry[i]=ARF_NUM+i (32..63); spec_head=retire_head=0; tail=6'b100000.
//    Resulting outputs: count=32, empty=0, fl_PRF_num_out=32, grant=0.
//  - Free count and empty:
//    - count = tail - spec_head, modulo 64.
//    - empty = (count==0).
//    - fl_PRF_num_out = entry[spec_head[4:0]], read combinationally with no write bypass.
//  - Grant: grant = id_dispatch_req_in & ~empty & ~(ROB_commit_in & ROB_branch_mispredict_in).
//  - Pop: on grant, spec_head += 1 at the posedge. Latency 0: the tag is consumed in the same cycle.
//  - Push: on commit & has_dest:
//    - entry[tail] <= ROB_old_PRF_num_in; tail += 1; retire_head += 1.
//    - The pushed tag is visible from the next cycle.
//  - Commit without dest: no pointer changes.
//  - Squash: on commit & mispredict, spec_head <= retire_head_next.
//    - retire_head_next includes this cycle's increment when has_dest=1.
//    - Every tag allocated after the branch is returned in one cycle; pops that cycle are suppressed.
//  - Simultaneous pop and push: both apply; count is unchanged.
//  - Wrap: all pointers wrap modulo 64. The index wraps 31 -> 0 and the wrap bit toggles.
//  - Empty with push in the same cycle: grant=0 that cycle; the tag is poppable next cycle.
//  - Overflow (push while count==FL_SIZE) cannot occur legally. Simulation-only $error.
//  - reset asserted mid-operation returns all state to the reset values asynchronously.
// CONFIGURATION
//  FL_EMPTY_BYPASS_EN
//   - Defined: when empty and commit & has_dest & ~mispredict, the tag is bypassed.
//     fl_PRF_num_out = ROB_old_PRF_num_in and grant = id_dispatch_req_in.
//     The pushed tag is consumed directly: tail, spec_head and retire_head all advance; entry write optional.
//   - Undefined: no bypass; behaviour exactly as above.
// STRUCTURE
//  - Package prf_pkg:
//    - PRF_width, ARF_width, FL_SIZE, `define-equivalent localparams.
//    - typedef logic [PRF_width-1:0] prf_tag_t.
//    - typedef logic [$clog2(FL_SIZE):0] fl_ptr_t.
//  - One sub-module: fl_wrap_ptr. A wrap-bit pointer register with inc/load, async active-low clear,
//    and a parameterised reset value. Instantiated three times.
// TESTING
//  1 Reset, then release -> count=32, empty=0, out=32, grant=0 while req=0.
//  2 req=1 for 32 cycles -> out 32,33,..,63 each with grant=1. Then empty=1, grant=0, count=0.
//    With FL_EMPTY_BYPASS_EN undefined: from empty, commit old=5 -> grant=0 that cycle; next cycle out=5, count=1.
//  3 From reset, req=1 for 3 cycles (32,33,34 popped). Then commit has_dest=1, old=7, mispredict=1, req=1 ->
//    grant=0; next cycle count=32, out=33.
//  4 Same-cycle pop and push at count=16 -> count stays 16. Pushed tag is returned after the FIFO drains past it.
//  5 Run 100 alloc/commit pairs -> pointers wrap. No tag is duplicated or lost (the scoreboard set of 64 tags
//    is conserved). Reset asserted mid-run -> state is back to the test 1 values before the next posedge.
//  6 With FL_EMPTY_BYPASS_EN defined: empty, req=1, commit old=9 -> same-cycle grant=1 and out=9; count stays 0.

Source files
------------

// File: rtl/prf_pkg.sv
// -----------------------------------------------------------------------------
// prf_pkg
// Shared sizes and types for the PRF free list.
//   PRF_width / ARF_width : tag and architectural index widths
//   FL_SIZE               : free-list depth (PRF_NUM - ARF_NUM, power of two)
//   prf_tag_t             : physical register tag
//   fl_ptr_t              : free-list pointer, index plus one wrap bit
// -----------------------------------------------------------------------------
package prf_pkg;
    localparam int PRF_width = 6;
    localparam int ARF_width = 5;
    localparam int PRF_NUM   = 1 << PRF_width;
    localparam int ARF_NUM   = 1 << ARF_width;
    localparam int FL_SIZE   = PRF_NUM - ARF_NUM;
    localparam int FL_IDX_W  = $clog2(FL_SIZE);

    typedef logic [PRF_width-1:0] prf_tag_t;
    typedef logic [FL_IDX_W:0]    fl_ptr_t;
endpackage

// File: rtl/prf_free_list_if.sv
// -----------------------------------------------------------------------------
// prf_free_list_if
// Dispatch and ROB-commit signals of the free list.
//   master : dispatch/ROB side (drives requests and commit info)
//   slave  : free list (drives tag, grant, empty, free count)
// -----------------------------------------------------------------------------
interface prf_free_list_if;
    import prf_pkg::*;

    logic     id_dispatch_req_in;
    prf_tag_t fl_PRF_num_out;
    logic     fl_grant_out;
    logic     fl_empty_out;
    fl_ptr_t  fl_free_count_out;
    logic     ROB_commit_in;
    logic     ROB_has_dest_in;
    prf_tag_t ROB_old_PRF_num_in;
    logic     ROB_branch_mispredict_in;

    modport master (
        output id_dispatch_req_in, ROB_commit_in, ROB_has_dest_in,
               ROB_old_PRF_num_in, ROB_branch_mispredict_in,
        input  fl_PRF_num_out, fl_grant_out, fl_empty_out, fl_free_count_out
    );

    modport slave (
        input  id_dispatch_req_in, ROB_commit_in, ROB_has_dest_in,
               ROB_old_PRF_num_in, ROB_branch_mispredict_in,
        output fl_PRF_num_out, fl_grant_out, fl_empty_out, fl_free_count_out
    );
endinterface

// File: rtl/fl_wrap_ptr.sv
// -----------------------------------------------------------------------------
// fl_wrap_ptr
// Wrap-bit pointer register (index + wrap bit), wraps naturally modulo 2^W.
//   clock, reset : clock, async active-low clear to RST_VAL
//   i_inc        : advance by one
//   i_load       : load i_load_val (has priority over i_inc)
//   o_ptr        : current pointer
// -----------------------------------------------------------------------------
module fl_wrap_ptr
    import prf_pkg::*;
#(
    parameter fl_ptr_t RST_VAL = '0
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    i_inc,
    input  logic    i_load,
    input  fl_ptr_t i_load_val,
    output fl_ptr_t o_ptr
);
    fl_ptr_t r_ptr;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            r_ptr <= RST_VAL;
        else if (i_load)
            r_ptr <= i_load_val;
        else if (i_inc)
            r_ptr <= r_ptr + fl_ptr_t'(1);
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/prf_free_list.sv
// -----------------------------------------------------------------------------
// prf_free_list
// Circular FIFO of free PRF tags. Dispatch pops at the speculative head, ROB
// commit pushes stale tags at the tail, and a retirement head lets a
// mispredicted branch restore the speculative head in one cycle.
//   clock, reset : clock, async active-low reset
//   fl (slave)   : dispatch request / grant / tag, empty, free count,
//                  ROB commit, has_dest, old tag, mispredict
// Optional feature macro: FL_EMPTY_BYPASS_EN -- when the list is empty and a
// non-squashing commit returns a tag, that tag is handed straight to dispatch.
// -----------------------------------------------------------------------------
module prf_free_list
    import prf_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    prf_free_list_if.slave  fl
);
    prf_tag_t r_entry [FL_SIZE];

    fl_ptr_t  w_spec_head, w_retire_head, w_tail, w_retire_head_next, w_count;
    logic     w_empty, w_push, w_squash, w_bypass, w_grant;

    // Pointers carry a wrap bit, so plain subtraction gives 0..FL_SIZE.
    assign w_count  = w_tail - w_spec_head;
    assign w_empty  = (w_count == '0);
    assign w_push   = fl.ROB_commit_in & fl.ROB_has_dest_in;
    assign w_squash = fl.ROB_commit_in & fl.ROB_branch_mispredict_in;

`ifdef FL_EMPTY_BYPASS_EN
    assign w_bypass = w_empty & w_push & ~fl.ROB_branch_mispredict_in;
`else
    assign w_bypass = 1'b0;
`endif

    // A squash returns every speculative tag this cycle, so any pop is dropped.
    assign w_grant = fl.id_dispatch_req_in & (~w_empty | w_bypass) & ~w_squash;

    // Squash target includes the retirement happening this very cycle.
    assign w_retire_head_next = w_retire_head + fl_ptr_t'(w_push);

    fl_wrap_ptr #(.RST_VAL('0)) u_spec_head (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_grant),
        .i_load     (w_squash),
        .i_load_val (w_retire_head_next),
        .o_ptr      (w_spec_head)
    );

    fl_wrap_ptr #(.RST_VAL('0)) u_retire_head (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_push),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_retire_head)
    );

    fl_wrap_ptr #(.RST_VAL(fl_ptr_t'(FL_SIZE))) u_tail (
        .clock      (clock),
        .reset      (reset),
        .i_inc      (w_push),
        .i_load     (1'b0),
        .i_load_val ('0),
        .o_ptr      (w_tail)
    );

    // After reset the list holds every tag not mapped to an ARF register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < FL_SIZE; i++)
                r_entry[i] <= prf_tag_t'(ARF_NUM + i);
        end else if (w_push) begin
            r_entry[w_tail[FL_IDX_W-1:0]] <= fl.ROB_old_PRF_num_in;
        end
    end

    // No write bypass: a pushed tag becomes visible at the head next cycle.
    assign fl.fl_PRF_num_out    = w_bypass ? fl.ROB_old_PRF_num_in
                                           : r_entry[w_spec_head[FL_IDX_W-1:0]];
    assign fl.fl_grant_out      = w_grant;
    assign fl.fl_empty_out      = w_empty;
    assign fl.fl_free_count_out = w_count;

    // A push into a full list means the ROB released a tag it never held.
    always @(posedge clock) begin
        if (reset && w_push)
            assert (w_count != fl_ptr_t'(FL_SIZE))
                else $error("prf_free_list: push into full free list");
    end
endmodule

// File: tb/tb_prf_free_list.sv
module tb_prf_free_list;
    import prf_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    prf_free_list_if fl();

    prf_free_list dut (
        .clock (clock),
        .reset (reset),
        .fl    (fl)
    );

    // Reference model: free tags in FIFO order, in-flight renames, rename maps.
    typedef struct { int arch; prf_tag_t newt; prf_tag_t oldt; } rob_t;
    typedef struct { logic grant; prf_tag_t tag; } exp_t;

    prf_tag_t free_q [$];
    rob_t     rob_q  [$];
    prf_tag_t spec_map [ARF_NUM];
    prf_tag_t arch_map [ARF_NUM];
    exp_t     exp_q  [$];
    prf_tag_t seen_q [$];
    bit       collect = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        free_q.delete();
        rob_q.delete();
        exp_q.delete();
        for (int i = 0; i < FL_SIZE; i++) free_q.push_back(prf_tag_t'(ARF_NUM + i));
        for (int i = 0; i < ARF_NUM; i++) begin
            spec_map[i] = prf_tag_t'(i);
            arch_map[i] = prf_tag_t'(i);
        end
    endtask

    task automatic drive_idle();
        fl.id_dispatch_req_in       = 1'b0;
        fl.ROB_commit_in            = 1'b0;
        fl.ROB_has_dest_in          = 1'b0;
        fl.ROB_old_PRF_num_in       = '0;
        fl.ROB_branch_mispredict_in = 1'b0;
    endtask

    // Assert reset between edges and check it takes effect with no clock edge.
    task automatic do_reset();
        @(negedge clock);
        drive_idle();
        #1 reset = 1'b0;
        #1;
        model_reset();
        chk("rst_count", fl.fl_free_count_out, 32);
        chk("rst_empty", fl.fl_empty_out, 0);
        chk("rst_out",   fl.fl_PRF_num_out, 32);
        chk("rst_grant", fl.fl_grant_out, 0);
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    // One cycle: check registered state, drive inputs, queue expectation,
    // advance the model, then go idle just after the posedge.
    task automatic step(input bit req, input bit commit, input bit hd_in,
                        input bit mis, input int arch);
        bit       hd, empty, byp, grant;
        prf_tag_t old_t, t;
        rob_t     c;
        hd = hd_in && (rob_q.size() > 0);
        @(negedge clock);
        chk("count", fl.fl_free_count_out, free_q.size());
        chk("empty", fl.fl_empty_out, int'(free_q.size() == 0));
        if (free_q.size() > 0) chk("head_tag", fl.fl_PRF_num_out, free_q[0]);
        old_t = (commit && hd) ? rob_q[0].oldt : prf_tag_t'($urandom);
        fl.id_dispatch_req_in       = req;
        fl.ROB_commit_in            = commit;
        fl.ROB_has_dest_in          = hd;
        fl.ROB_old_PRF_num_in       = old_t;
        fl.ROB_branch_mispredict_in = mis;
        empty = (free_q.size() == 0);
        byp   = 1'b0;
`ifdef FL_EMPTY_BYPASS_EN
        byp   = empty && commit && hd && !mis;
`endif
        grant = req && (!empty || byp) && !(commit && mis);
        if (req) exp_q.push_back('{grant, byp ? old_t : (empty ? prf_tag_t'(0) : free_q[0])});
        if (commit && hd) begin
            c = rob_q.pop_front();
            arch_map[c.arch] = c.newt;
            free_q.push_back(old_t);
        end
        if (commit && mis) begin
            for (int i = rob_q.size() - 1; i >= 0; i--) free_q.push_front(rob_q[i].newt);
            rob_q.delete();
            spec_map = arch_map;
        end
        if (grant) begin
            t = free_q.pop_front();
            rob_q.push_back('{arch, t, spec_map[arch]});
            spec_map[arch] = t;
        end
        @(posedge clock);
        #1 drive_idle();
    endtask

    // Monitor: compares each dispatch request against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (fl.id_dispatch_req_in === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("exp_avail", 0, 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("grant", fl.fl_grant_out, e.grant);
                    if (e.grant) begin
                        chk("pop_tag", fl.fl_PRF_num_out, e.tag);
                        if (collect) seen_q.push_back(fl.fl_PRF_num_out);
                    end
                end
            end else begin
                chk("grant_idle", fl.fl_grant_out, 0);
            end
        end
    end

    initial begin
        bit used [PRF_NUM];
        int distinct;
        drive_idle();
        model_reset();

        // Reset values
        do_reset();

        // Drain all 32 tags, then return one into the empty list
        for (int k = 0; k < 32; k++) step(1, 0, 0, 0, (k + 5) % 32);
        #1;
        chk("t2_count", fl.fl_free_count_out, 0);
        chk("t2_empty", fl.fl_empty_out, 1);
        step(1, 1, 1, 0, 0);
        #1;
`ifdef FL_EMPTY_BYPASS_EN
        chk("t6_count", fl.fl_free_count_out, 0);
        chk("t6_empty", fl.fl_empty_out, 1);
`else
        chk("t2_out5",   fl.fl_PRF_num_out, 5);
        chk("t2_count1", fl.fl_free_count_out, 1);
`endif

        // Squash on a committing mispredicted branch
        do_reset();
        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, k + 1);
        step(1, 1, 1, 1, 0);
        #1;
        chk("t3_count", fl.fl_free_count_out, 32);
        chk("t3_out",   fl.fl_PRF_num_out, 33);

        // Simultaneous pop and push at count 16
        do_reset();
        for (int k = 0; k < 16; k++) step(1, 0, 0, 0, (k + 7) % 32);
        step(1, 1, 1, 0, 20);
        #1;
        chk("t4_count", fl.fl_free_count_out, 16);
        for (int k = 0; k < 15; k++) step(1, 0, 0, 0, 21);
        #1;
        chk("t4_pushed_out", fl.fl_PRF_num_out, 7);

        // Randomized traffic with a mid-run reset
        do_reset();
        for (int n = 0; n < 800; n++) begin
            bit req, commit, hd, mis;
            req    = ($urandom_range(0, 3) != 0);
            commit = 1'b0; hd = 1'b0; mis = 1'b0;
            if (rob_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                commit = 1'b1; hd = 1'b1;
                mis    = ($urandom_range(0, 19) == 0);
            end else if ($urandom_range(0, 7) == 0) begin
                commit = 1'b1;
                mis    = ($urandom_range(0, 3) == 0);
            end
            step(req, commit, hd, mis, $urandom_range(0, ARF_NUM - 1));
            if (n == 400) do_reset();
        end

        // Retire everything, then drain and check the 64 tags are conserved
        while (rob_q.size() > 0) step(0, 1, 1, 0, 0);
        collect = 1'b1;
        for (int k = 0; k < FL_SIZE; k++) step(1, 0, 0, 0, k);
        collect = 1'b0;
        chk("drain_len", seen_q.size(), FL_SIZE);
        foreach (used[i]) used[i] = 1'b0;
        foreach (seen_q[i]) used[seen_q[i]] = 1'b1;
        foreach (arch_map[i]) used[arch_map[i]] = 1'b1;
        distinct = 0;
        foreach (used[i]) if (used[i]) distinct++;
        chk("tag_conservation", distinct, PRF_NUM);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
